// File: rtl/sdc_writer_pkg.sv
// Shared types and constants for the SD-card block write path.
// Used by sdc_crc16_serial and sdc_block_serializer (optional feature macro: SDC_BUSY_TIMEOUT_EN).
package sdc_writer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CRC,
    S_ENDB,
    S_RESP_WAIT,
    S_RESP,
    S_BUSYW,
    S_ABORT
  } state_e;

  typedef enum logic [2:0] {
    ST_OK            = 3'd0,
    ST_CRC_REJECT    = 3'd1,
    ST_WRITE_REJECT  = 3'd2,
    ST_UNDERRUN      = 3'd3,
    ST_RESP_TIMEOUT  = 3'd4,
    ST_BUSY_TIMEOUT  = 3'd5
  } status_e;

  localparam logic [15:0] CRC16_POLY     = 16'h1021;
  localparam logic [2:0]  TOK_ACCEPT     = 3'b010;
  localparam logic [2:0]  TOK_CRC_REJECT = 3'b101;

  // One MSB-first step of CRC16-CCITT (init 0, no reflection, no final XOR).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sdc_crc16_serial.sv
// Bit-serial CRC16 accumulator for the DAT0 data field.
// clr restarts the CRC at zero; en advances it by one bit.
module sdc_crc16_serial
  import sdc_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_crc <= 16'h0000;
    end else if (en) begin
      r_crc <= crc16_step(r_crc, din);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/sdc_block_serializer.sv
// Drives one data block onto DAT0 (start, data, CRC16, end) and reports the card's response.
// Optional busy timeout enabled by defining SDC_BUSY_TIMEOUT_EN.
module sdc_block_serializer
  import sdc_writer_pkg::*;
#(
  parameter int BLOCK_BYTES = 512,
  parameter int RESP_WINDOW = 16
`ifdef SDC_BUSY_TIMEOUT_EN
  ,
  parameter int BUSY_TIMEOUT = 65535
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_en,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       dat_out,
  output logic       dat_oe,
  input  logic       dat_in,
  output logic       busy,
  output logic       done,
  output logic [2:0] status
);

  localparam logic [15:0] LAST_DATA_BIT = 16'(BLOCK_BYTES * 8 - 1);
  localparam logic [15:0] RESP_LAST     = 16'(RESP_WINDOW - 1);
`ifdef SDC_BUSY_TIMEOUT_EN
  localparam logic [15:0] BUSY_LAST     = 16'(BUSY_TIMEOUT - 1);
`endif

  state_e      r_state;
  state_e      w_state_nxt;
  status_e     r_status;
  status_e     w_status_nxt;
  logic [15:0] r_cnt;
  logic [7:0]  r_hold;
  logic [7:0]  r_shift;
  logic        r_hold_full;
  logic [2:0]  r_tok;
  logic        w_load;
  logic        w_hs;
  logic        w_cnt_run;
  logic [15:0] w_crc;

  sdc_crc16_serial u_crc (
    .clk  (clk),
    .reset(reset),
    .clr  (r_state == S_IDLE),
    .en   (bit_en && (r_state == S_DATA)),
    .din  (r_shift[7]),
    .crc  (w_crc)
  );

  assign byte_ready = !r_hold_full && ((r_state == S_START) || (r_state == S_DATA));
  assign w_hs       = byte_valid && byte_ready;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_ABORT);
  assign status     = r_status;

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_load       = 1'b0;
    w_cnt_run    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_START;
      end
      S_START: begin
        if (bit_en) begin
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_status_nxt = ST_UNDERRUN;
            w_state_nxt  = S_ABORT;
          end
        end
      end
      S_DATA: begin
        w_cnt_run = 1'b1;
        // The final byte needs no refill; every other byte boundary does.
        if (bit_en && (r_cnt[2:0] == 3'd7)) begin
          if (r_cnt == LAST_DATA_BIT) begin
            w_state_nxt = S_CRC;
          end else if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_status_nxt = ST_UNDERRUN;
            w_state_nxt  = S_ABORT;
          end
        end
      end
      S_CRC: begin
        w_cnt_run = 1'b1;
        if (bit_en && (r_cnt == 16'd15)) w_state_nxt = S_ENDB;
      end
      S_ENDB: begin
        if (bit_en) w_state_nxt = S_RESP_WAIT;
      end
      S_RESP_WAIT: begin
        w_cnt_run = 1'b1;
        if (bit_en) begin
          if (!dat_in) begin
            w_state_nxt = S_RESP;
          end else if (r_cnt == RESP_LAST) begin
            w_status_nxt = ST_RESP_TIMEOUT;
            w_state_nxt  = S_ABORT;
          end
        end
      end
      S_RESP: begin
        w_cnt_run = 1'b1;
        // Three token bits, then the token end bit on count 3.
        if (bit_en && (r_cnt == 16'd3)) begin
          if (r_tok == TOK_ACCEPT) begin
            w_state_nxt = S_BUSYW;
          end else if (r_tok == TOK_CRC_REJECT) begin
            w_status_nxt = ST_CRC_REJECT;
            w_state_nxt  = S_ABORT;
          end else begin
            w_status_nxt = ST_WRITE_REJECT;
            w_state_nxt  = S_ABORT;
          end
        end
      end
      S_BUSYW: begin
`ifdef SDC_BUSY_TIMEOUT_EN
        w_cnt_run = 1'b1;
`endif
        if (bit_en) begin
          if (dat_in) begin
            w_status_nxt = ST_OK;
            w_state_nxt  = S_ABORT;
          end
`ifdef SDC_BUSY_TIMEOUT_EN
          else if (r_cnt == BUSY_LAST) begin
            w_status_nxt = ST_BUSY_TIMEOUT;
            w_state_nxt  = S_ABORT;
          end
`endif
        end
      end
      S_ABORT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    dat_oe  = 1'b0;
    dat_out = 1'b1;
    unique case (r_state)
      S_START: begin dat_oe = 1'b1; dat_out = 1'b0; end
      S_DATA:  begin dat_oe = 1'b1; dat_out = r_shift[7]; end
      S_CRC:   begin dat_oe = 1'b1; dat_out = w_crc[4'd15 - r_cnt[3:0]]; end
      S_ENDB:  begin dat_oe = 1'b1; dat_out = 1'b1; end
      default: begin dat_oe = 1'b0; dat_out = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_status    <= ST_OK;
      r_hold_full <= 1'b0;
      r_cnt       <= 16'h0000;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
      // A load and a new byte on the same clock leave the holding register full.
      if (r_state == S_IDLE) r_hold_full <= 1'b0;
      else                   r_hold_full <= (r_hold_full && !w_load) || w_hs;
      if (w_state_nxt != r_state)  r_cnt <= 16'h0000;
      else if (bit_en && w_cnt_run) r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) r_hold <= byte_data;
    if (w_load)                            r_shift <= r_hold;
    else if (bit_en && r_state == S_DATA)  r_shift <= {r_shift[6:0], 1'b0};
    if (bit_en && r_state == S_RESP) r_tok <= {r_tok[1:0], dat_in};
  end

endmodule
